// File: rtl/parity_frame_tx.sv
// Serialises DATA_W-bit words LSB first and appends a parity beat to each frame.
// Optional macro PARITY_ODD_EN selects odd parity; the default build uses even parity.
module parity_frame_tx #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              ser_valid,
    input  logic              ser_ready,
    output logic              ser_out,
    output logic              ser_last,
    output logic              par_out,
    output logic [CNT_W-1:0]  frame_cnt,
    output logic              busy
);
    localparam int CW = $clog2(DATA_W);
    localparam logic [CW-1:0] LAST_CNT = CW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SEND, PAR} state_t;

    state_t             state_reg;
    logic [DATA_W-1:0]  shreg_reg;
    logic [CW-1:0]      cnt_reg;
    logic               acc_reg;
    logic               par_reg;
    logic [CNT_W-1:0]   frame_cnt_reg;
    logic               par_bit;
    logic               beat_acc;
    logic               word_acc;

`ifdef PARITY_ODD_EN
    assign par_bit = ~acc_reg;
`else
    assign par_bit = acc_reg;
`endif

    assign ser_valid = (state_reg != IDLE);
    assign ser_last  = (state_reg == PAR);
    assign busy      = (state_reg != IDLE);
    // A new word may enter while the parity beat leaves, so frames run back to back.
    assign in_ready  = (state_reg == IDLE) | ((state_reg == PAR) & ser_ready);
    assign beat_acc  = ser_valid & ser_ready;
    assign word_acc  = in_valid & in_ready;
    assign par_out   = par_reg;
    assign frame_cnt = frame_cnt_reg;

    always_comb begin
        ser_out = 1'b0;
        case (state_reg)
            SEND:    ser_out = shreg_reg[0];
            PAR:     ser_out = par_bit;
            default: ser_out = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= IDLE;
            shreg_reg     <= '0;
            cnt_reg       <= '0;
            acc_reg       <= 1'b0;
            par_reg       <= 1'b0;
            frame_cnt_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (word_acc) begin
                        shreg_reg <= in_data;
                        cnt_reg   <= '0;
                        acc_reg   <= 1'b0;
                        state_reg <= SEND;
                    end
                end
                SEND: begin
                    if (beat_acc) begin
                        acc_reg   <= acc_reg ^ shreg_reg[0];
                        shreg_reg <= shreg_reg >> 1;
                        cnt_reg   <= cnt_reg + 1'b1;
                        if (cnt_reg == LAST_CNT)
                            state_reg <= PAR;
                    end
                end
                PAR: begin
                    if (beat_acc) begin
                        par_reg       <= par_bit;
                        frame_cnt_reg <= frame_cnt_reg + 1'b1;
                        if (word_acc) begin
                            shreg_reg <= in_data;
                            cnt_reg   <= '0;
                            acc_reg   <= 1'b0;
                            state_reg <= SEND;
                        end else begin
                            state_reg <= IDLE;
                        end
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_parity_frame_tx.sv
// Randomised and directed bench for parity_frame_tx; expected beats come from a queue model
// holding the bit stream that every accepted word must produce.
module tb_parity_frame_tx;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              ser_valid;
    logic              ser_ready;
    logic              ser_out;
    logic              ser_last;
    logic              par_out;
    logic [CNT_W-1:0]  frame_cnt;
    logic              busy;

    parity_frame_tx #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .ser_valid(ser_valid), .ser_ready(ser_ready), .ser_out(ser_out),
        .ser_last(ser_last), .par_out(par_out), .frame_cnt(frame_cnt), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Model state: pending beats as {last, bit}, plus expected counters.
    logic [1:0]       q[$];
    logic [CNT_W-1:0] exp_cnt = '0;
    logic             exp_par = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic parity_of(input logic [DATA_W-1:0] d);
`ifdef PARITY_ODD_EN
        return ~(^d);
`else
        return ^d;
`endif
    endfunction

    // One clock cycle, starting and ending at a falling edge.
    task automatic cycle(input logic v, input logic [DATA_W-1:0] d, input logic r, output logic took);
        logic       exp_ready;
        logic       beat;
        logic [1:0] b;
        in_valid  = v;
        in_data   = d;
        ser_ready = r;
        #1;
        exp_ready = (q.size() == 0) || (q.size() == 1 && r);
        chk("in_ready", in_ready, exp_ready);
        chk("ser_valid", ser_valid, q.size() != 0);
        if (q.size() != 0) begin
            chk("ser_out", ser_out, q[0][0]);
            chk("ser_last", ser_last, q[0][1]);
        end
        beat = (q.size() != 0) && r;
        took = v && exp_ready;
        if (beat) begin
            b = q.pop_front();
            if (b[1]) begin
                exp_cnt++;
                exp_par = b[0];
            end
        end
        if (took) begin
            for (int i = 0; i < DATA_W; i++) q.push_back({1'b0, d[i]});
            q.push_back({1'b1, parity_of(d)});
            $display("word accepted data=%02h parity=%0b t=%0t", d, parity_of(d), $time);
        end
        @(posedge clk);
        @(negedge clk);
        chk("frame_cnt", frame_cnt, exp_cnt);
        chk("par_out", par_out, exp_par);
        chk("busy", busy, q.size() != 0);
    endtask

    task automatic send_word(input logic [DATA_W-1:0] d, output int n);
        logic took;
        took = 1'b0;
        n = 0;
        for (int k = 0; k < 40 && !took; k++) begin
            cycle(1'b1, d, 1'b1, took);
            n++;
        end
        if (!took) chk("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic drain();
        logic took;
        for (int k = 0; k < 100 && q.size() != 0; k++) cycle(1'b0, '0, 1'b1, took);
        if (q.size() != 0) chk("drain_timeout", q.size(), 32'd0);
    endtask

    task automatic reset_mid();
        #2 rst = 1'b1;
        #1;
        q.delete();
        exp_cnt = '0;
        exp_par = 1'b0;
        chk("rst_busy", busy, 32'd0);
        chk("rst_ser_valid", ser_valid, 32'd0);
        chk("rst_ser_last", ser_last, 32'd0);
        chk("rst_frame_cnt", frame_cnt, 32'd0);
        chk("rst_par_out", par_out, 32'd0);
        chk("rst_in_ready", in_ready, 32'd1);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        logic took;
        int   n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        ser_ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("init_busy", busy, 32'd0);
        chk("init_ser_valid", ser_valid, 32'd0);
        chk("init_ser_last", ser_last, 32'd0);
        chk("init_frame_cnt", frame_cnt, 32'd0);
        chk("init_par_out", par_out, 32'd0);
        chk("init_in_ready", in_ready, 32'd1);
        rst = 1'b0;

        // Partial frame cut by reset, then a clean frame.
        send_word(8'h3C, n);
        repeat (4) cycle(1'b0, 8'h00, 1'b1, took);
        reset_mid();
        send_word(8'h00, n);
        drain();

        send_word(8'hA5, n);
        drain();

        // Backpressure in the middle of a frame.
        send_word(8'h07, n);
        repeat (3) cycle(1'b0, 8'hFF, 1'b1, took);
        repeat (3) cycle(1'b1, 8'hFF, 1'b0, took);
        drain();

        // Back-to-back: second word waits exactly one frame of beats.
        send_word(8'h01, n);
        send_word(8'hFF, n);
        chk("b2b_accept_cycles", n, DATA_W + 1);
        drain();

        for (int k = 0; k < 600; k++)
            cycle(1'($urandom_range(0, 1)), DATA_W'($urandom), ($urandom_range(0, 3) != 0), took);
        drain();

        // Counter wrap after 2^CNT_W frames.
        reset_mid();
        for (int k = 0; k < (1 << CNT_W); k++) send_word(DATA_W'($urandom), n);
        drain();
        chk("wrap_frame_cnt", frame_cnt, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
